// File: rtl/latch_bank_wr_sched.sv
// latch_bank_wr_sched
//   Round-robin write scheduler for a bank of DEPTH level-sensitive latches
//   that share one data bus. Each accepted write runs SETUP -> OPEN -> HOLD,
//   so exactly one latch enable pulses for one cycle, and lat_d is stable
//   for at least one cycle on each side of that pulse.
//
//   Optional feature (macro LBW_BACK2BACK_EN):
//     defined   - HOLD also arbitrates and may go straight to SETUP (3 cycles/write)
//     undefined - HOLD always returns to IDLE (4 cycles/write)
//
//   Handshake: a requester holds req/wr_addr/wr_data stable until it sees its
//   one-cycle gnt pulse, and may drop req in that same cycle. req is only
//   sampled at an arbitration point (IDLE, or HOLD when back-to-back is on).
//   A req withdrawn before it is sampled is never granted.
//
//   All outputs are registered. dbg_state exposes the FSM state for checkers.
module latch_bank_wr_sched #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*AW-1:0]    wr_addr,
   input  logic [NREQ*WIDTH-1:0] wr_data,
   output logic [NREQ-1:0]       gnt,
   output logic [WIDTH-1:0]      lat_d,
   output logic [DEPTH-1:0]      lat_en,
   output logic                  busy,
   output logic                  err,
   output logic [1:0]            dbg_state
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SETUP = 2'd1,
      S_OPEN  = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   // registered state and outputs
   state_t           r_state;
   logic [PW-1:0]    r_rr_ptr;
   logic [AW-1:0]    r_addr;
   logic [NREQ-1:0]  r_gnt;
   logic [WIDTH-1:0] r_lat_d;
   logic [DEPTH-1:0] r_lat_en;
   logic             r_busy;
   logic             r_err;

   // arbiter results
   logic             w_win_found;
   logic [PW-1:0]    w_win_idx;
   logic [AW-1:0]    w_win_addr;
   logic [WIDTH-1:0] w_win_data;
   logic [PW-1:0]    w_ptr_after_win;
   int               w_idx;

   // decoded enable for the captured address (all zero when out of range)
   logic [DEPTH-1:0] w_addr_dec;

   // next-state values
   state_t           w_state_nxt;
   logic             w_grant;
   logic [PW-1:0]    w_rr_ptr_nxt;
   logic [AW-1:0]    w_addr_nxt;
   logic [NREQ-1:0]  w_gnt_nxt;
   logic [WIDTH-1:0] w_lat_d_nxt;
   logic [DEPTH-1:0] w_lat_en_nxt;
   logic             w_busy_nxt;
   logic             w_err_nxt;

   // Round-robin search: first set req bit at or above r_rr_ptr, wrapping.
   always_comb begin
      w_win_found = 1'b0;
      w_win_idx   = '0;
      w_win_addr  = '0;
      w_win_data  = '0;
      w_idx       = 0;
      for (int k = 0; k < NREQ; k++) begin
         w_idx = int'(r_rr_ptr) + k;
         if (w_idx >= NREQ) begin
            w_idx = w_idx - NREQ;
         end
         if (!w_win_found && req[w_idx]) begin
            w_win_found = 1'b1;
            w_win_idx   = PW'(w_idx);
            w_win_addr  = wr_addr[w_idx*AW +: AW];
            w_win_data  = wr_data[w_idx*WIDTH +: WIDTH];
         end
      end
   end

   // Pointer moves to the requester just after the winner, wrapping at NREQ.
   always_comb begin
      if (int'(w_win_idx) == NREQ - 1) begin
         w_ptr_after_win = '0;
      end else begin
         w_ptr_after_win = w_win_idx + PW'(1);
      end
   end

   // One-hot decode of the captured entry address; out-of-range decodes to 0.
   always_comb begin
      w_addr_dec = '0;
      for (int e = 0; e < DEPTH; e++) begin
         w_addr_dec[e] = (int'(r_addr) == e);
      end
   end

   // Next-state and registered-output values for the SETUP/OPEN/HOLD sequence.
   always_comb begin
      w_state_nxt  = r_state;
      w_grant      = 1'b0;
      w_rr_ptr_nxt = r_rr_ptr;
      w_addr_nxt   = r_addr;
      w_gnt_nxt    = '0;
      w_lat_d_nxt  = r_lat_d;
      w_lat_en_nxt = '0;
      w_err_nxt    = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_grant = w_win_found;
         end
         S_SETUP: begin
            // data has been stable for a full cycle; open the target latch
            w_state_nxt  = S_OPEN;
            w_lat_en_nxt = w_addr_dec;
         end
         S_OPEN: begin
            w_state_nxt = S_HOLD;
         end
         S_HOLD: begin
            w_state_nxt = S_IDLE;
`ifdef LBW_BACK2BACK_EN
            // lat_d only moves on SETUP entry, so the hold cycle stays intact
            w_grant = w_win_found;
`endif
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // acceptance: capture the winner and launch its SETUP cycle
      if (w_grant) begin
         w_state_nxt  = S_SETUP;
         w_rr_ptr_nxt = w_ptr_after_win;
         w_addr_nxt   = w_win_addr;
         w_gnt_nxt    = NREQ'(1) << w_win_idx;
         w_lat_d_nxt  = w_win_data;
         w_err_nxt    = (int'(w_win_addr) >= DEPTH);
      end

      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   // State and output registers; reset drops any in-flight write.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_rr_ptr <= '0;
         r_addr   <= '0;
         r_gnt    <= '0;
         r_lat_d  <= '0;
         r_lat_en <= '0;
         r_busy   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_rr_ptr <= w_rr_ptr_nxt;
         r_addr   <= w_addr_nxt;
         r_gnt    <= w_gnt_nxt;
         r_lat_d  <= w_lat_d_nxt;
         r_lat_en <= w_lat_en_nxt;
         r_busy   <= w_busy_nxt;
         r_err    <= w_err_nxt;
      end
   end

   assign gnt       = r_gnt;
   assign lat_d     = r_lat_d;
   assign lat_en    = r_lat_en;
   assign busy      = r_busy;
   assign err       = r_err;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_latch_bank_wr_sched.sv
// Directed bench for latch_bank_wr_sched: a DEPTH=4 instance (u0) and a
// DEPTH=3 instance (u1) share stimulus; u1 covers the out-of-range address.
module tb_latch_bank_wr_sched;
   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int AW    = 2;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req;
   logic [NREQ*AW-1:0]    wr_addr;
   logic [NREQ*WIDTH-1:0] wr_data;

   logic [NREQ-1:0]  gnt0;
   logic [WIDTH-1:0] lat_d0;
   logic [3:0]       lat_en0;
   logic             busy0, err0;
   logic [1:0]       st0;

   logic [NREQ-1:0]  gnt1;
   logic [WIDTH-1:0] lat_d1;
   logic [2:0]       lat_en1;
   logic             busy1, err1;
   logic [1:0]       st1;

   int n_total = 0;
   int n_pass  = 0;
   int n;

   always #5 clk = ~clk;

   latch_bank_wr_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(4)) u0 (
      .clk(clk), .rst(rst), .req(req), .wr_addr(wr_addr), .wr_data(wr_data),
      .gnt(gnt0), .lat_d(lat_d0), .lat_en(lat_en0), .busy(busy0), .err(err0),
      .dbg_state(st0)
   );

   latch_bank_wr_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(3)) u1 (
      .clk(clk), .rst(rst), .req(req), .wr_addr(wr_addr), .wr_data(wr_data),
      .gnt(gnt1), .lat_d(lat_d1), .lat_en(lat_en1), .busy(busy1), .err(err1),
      .dbg_state(st1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // advance one clock; sample/drive 1 time unit after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
      wr_addr[i*AW +: AW]       = a;
      wr_data[i*WIDTH +: WIDTH] = d;
   endtask

   task automatic wait_gnt(input string tag, output int cyc);
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (gnt0 == '0 && cyc < 10);
      chk(tag, 32'(gnt0 != '0), 32'd1);
   endtask

   task automatic wait_idle(input string tag);
      int c;
      c = 0;
      while (busy0 && c < 10) begin
         tick();
         c++;
      end
      chk(tag, 32'(busy0), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req = '0; wr_addr = '0; wr_data = '0;
      tick(); tick();
      chk("rst_gnt", 32'(gnt0), 32'h0);
      chk("rst_lat_d", 32'(lat_d0), 32'h0);
      chk("rst_lat_en", 32'(lat_en0), 32'h0);
      chk("rst_busy", 32'(busy0), 32'h0);
      chk("rst_err", 32'(err0), 32'h0);
      chk("rst_state", 32'(st0), 32'h0);
      rst = 1'b0;
      tick();

      // single write: requester 0, addr 2, data A5
      set_wr(0, 2'd2, 8'hA5);
      req = 4'b0001;
      tick();
      chk("sw_gnt", 32'(gnt0), 32'h1);
      chk("sw_busy1", 32'(busy0), 32'h1);
      chk("sw_lat_d1", 32'(lat_d0), 32'hA5);
      chk("sw_en1", 32'(lat_en0), 32'h0);
      chk("sw_state1", 32'(st0), 32'h1);
      req = 4'b0000;
      tick();
      chk("sw_en2", 32'(lat_en0), 32'h4);
      chk("sw_gnt2", 32'(gnt0), 32'h0);
      chk("sw_busy2", 32'(busy0), 32'h1);
      tick();
      chk("sw_en3", 32'(lat_en0), 32'h0);
      chk("sw_lat_d3", 32'(lat_d0), 32'hA5);
      chk("sw_busy3", 32'(busy0), 32'h1);
      tick();
      chk("sw_busy4", 32'(busy0), 32'h0);
      chk("sw_state4", 32'(st0), 32'h0);
      tick();
      chk("sw_lat_d_idle", 32'(lat_d0), 32'hA5);

      // fairness from a fresh pointer
      rst = 1'b1; tick(); rst = 1'b0;
      for (int i = 0; i < NREQ; i++) set_wr(i, AW'(i), 8'h10 + 8'(i));
      req = 4'b1111;
      for (int w = 0; w < NREQ; w++) begin
         wait_gnt("fair_wait", n);
         chk("fair_gnt", 32'(gnt0), 32'(1) << w);
         chk("fair_lat_d", 32'(lat_d0), 32'h10 + 32'(w));
         req[w] = 1'b0;
         tick();
         chk("fair_en", 32'(lat_en0), 32'(1) << w);
      end
      wait_idle("fair_idle");

      // pointer wrapped to 0
      req = 4'b1111;
      wait_gnt("wrap_wait", n);
      chk("wrap_gnt", 32'(gnt0), 32'h1);
      req = 4'b0010;
      wait_gnt("r1_wait", n);
      chk("r1_gnt", 32'(gnt0), 32'h2);
      // search starts at 2 and wraps to requester 0
      req = 4'b0001;
      wait_gnt("skip_wait", n);
      chk("skip_gnt", 32'(gnt0), 32'h1);
      // pointer now 1, so requester 1 wins over 0
      req = 4'b0011;
      wait_gnt("ptr1_wait", n);
      chk("ptr1_gnt", 32'(gnt0), 32'h2);
      req = 4'b0000;
      wait_idle("ptr_idle");

      // out-of-range address on the DEPTH=3 instance (pointer is 2 -> wraps to 0)
      set_wr(0, 2'd3, 8'h3C);
      req = 4'b0001;
      tick();
      chk("inv_gnt", 32'(gnt1), 32'h1);
      chk("inv_err", 32'(err1), 32'h1);
      chk("inv_en1", 32'(lat_en1), 32'h0);
      chk("inv_err_d4", 32'(err0), 32'h0);
      req = 4'b0000;
      tick();
      chk("inv_en2", 32'(lat_en1), 32'h0);
      chk("inv_err2", 32'(err1), 32'h0);
      chk("inv_en_d4", 32'(lat_en0), 32'h8);
      tick();
      chk("inv_en3", 32'(lat_en1), 32'h0);
      wait_idle("inv_idle");

      // reset in OPEN (pointer is 1)
      set_wr(1, 2'd1, 8'h77);
      req = 4'b0010;
      tick();
      chk("ro_gnt", 32'(gnt0), 32'h2);
      chk("ro_lat_d", 32'(lat_d0), 32'h77);
      req = 4'b0000;
      tick();
      chk("ro_en", 32'(lat_en0), 32'h2);
      rst = 1'b1;
      tick();
      chk("ro_en_rst", 32'(lat_en0), 32'h0);
      chk("ro_lat_d_rst", 32'(lat_d0), 32'h0);
      chk("ro_busy_rst", 32'(busy0), 32'h0);
      chk("ro_state_rst", 32'(st0), 32'h0);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("ro_gnt_after", 32'(gnt0), 32'h0);
         chk("ro_err_after", 32'(err0), 32'h0);
         chk("ro_en_after", 32'(lat_en0), 32'h0);
      end

      // consecutive writes with req held (pointer is 0 after reset)
      set_wr(0, 2'd0, 8'h50);
      set_wr(1, 2'd1, 8'h51);
      req = 4'b0011;
      wait_gnt("b2b_wait", n);
      chk("b2b_gnt0", 32'(gnt0), 32'h1);
      chk("b2b_lat_d0", 32'(lat_d0), 32'h50);
      tick();
      chk("b2b_en0", 32'(lat_en0), 32'h1);
      tick();
      chk("b2b_hold_en", 32'(lat_en0), 32'h0);
      chk("b2b_hold_d", 32'(lat_d0), 32'h50);
      chk("b2b_hold_busy", 32'(busy0), 32'h1);
      tick();
`ifdef LBW_BACK2BACK_EN
      chk("b2b_gnt1", 32'(gnt0), 32'h2);
      chk("b2b_busy", 32'(busy0), 32'h1);
      chk("b2b_lat_d1", 32'(lat_d0), 32'h51);
`else
      chk("b2b_idle_busy", 32'(busy0), 32'h0);
      chk("b2b_idle_gnt", 32'(gnt0), 32'h0);
      chk("b2b_idle_d", 32'(lat_d0), 32'h50);
      tick();
      chk("b2b_gnt1", 32'(gnt0), 32'h2);
      chk("b2b_lat_d1", 32'(lat_d0), 32'h51);
`endif
      req = 4'b0000;
      tick();
      chk("b2b_en1", 32'(lat_en0), 32'h2);
      wait_idle("b2b_idle");
      chk("b2b_final_d", 32'(lat_d0), 32'h51);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/latch_bank_wr_sched.md
# latch_bank_wr_sched

Write scheduler for a bank of `DEPTH` level-sensitive D latches, each `WIDTH` bits wide, that share one data bus. Up to `NREQ` requesters ask to write; the block arbitrates round-robin and drives the shared data bus and the per-entry latch enables in a fixed SETUP/OPEN/HOLD sequence. Only one latch is ever transparent, and its data is stable on both sides of the enable window. The block sits between the requesting logic and the latch bank, and is the only driver of the latch `d` and `en` pins.

## Interface
- `NREQ`, 4, number of requesters (≥2)
- `WIDTH`, 8, latch data width
- `DEPTH`, 4, number of latch entries (≥2, need not be a power of two)
- `AW`, $clog2(DEPTH), entry address width
- `clk`  in  1  clock; all state changes on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `req`  in  NREQ  per-requester write request, level
- `wr_addr`  in  NREQ*AW  packed entry addresses; requester i uses bits [i*AW +: AW]
- `wr_data`  in  NREQ*WIDTH  packed write data; requester i uses bits [i*WIDTH +: WIDTH]
- `gnt`  out  NREQ  one-hot, one-cycle acceptance pulse
- `lat_d`  out  WIDTH  shared data bus to all latch `d` pins
- `lat_en`  out  DEPTH  one-hot-or-zero latch enables
- `busy`  out  1  high in any state other than IDLE
- `err`  out  1  one-cycle pulse when the accepted address is ≥ DEPTH

## Operation
- FSM states: IDLE, SETUP, OPEN, HOLD. All outputs are registered.
- IDLE: if any `req` bit is high, pick the winner: the first set bit searching upward from `rr_ptr`, wrapping at NREQ. On the same edge:
  - capture the winner's `wr_addr` and `wr_data`
  - set `gnt[winner]`
  - set `rr_ptr` = (winner+1) mod NREQ
  - go to SETUP
- SETUP: `lat_d` = captured data, `lat_en` = 0, `gnt` high for this cycle only. If addr ≥ DEPTH, pulse `err` in this cycle. Go to OPEN.
- OPEN: `lat_en[addr]` = 1; `lat_en` stays 0 if addr ≥ DEPTH. `lat_d` unchanged. Go to HOLD.
- HOLD: `lat_en` = 0, `lat_d` unchanged. Go to IDLE; see Configuration for the back-to-back option.
- `lat_d` changes only on the edge that enters SETUP. In IDLE it keeps the last written value.
- Requester contract:
  - hold `req`, `wr_addr` and `wr_data` stable until its `gnt` is seen
  - may drop `req` in the `gnt` cycle
  - a `req` withdrawn before being sampled is simply never granted
- `req` is ignored outside the arbitration point.
- `rr_ptr` advances only on a grant.
- Reset values: state = IDLE, `rr_ptr` = 0, `gnt` = 0, `lat_d` = 0, `lat_en` = 0, `busy` = 0, `err` = 0.
- Reset mid-operation, in any state: on the reset edge `lat_en` goes to 0, `lat_d` to 0 and state to IDLE. The in-flight write is dropped with no further `gnt` or `err`. A latch that was open keeps whatever value it held.

## Timing
- `req` sampled high in IDLE at edge t gives:
  - `gnt` and `busy` high in cycle t+1 (SETUP)
  - `lat_en` high in cycle t+2 (OPEN)
  - `lat_en` low and `lat_d` still held in cycle t+3 (HOLD)
  - IDLE in cycle t+4
- One write takes 4 cycles; the next grant can be sampled at the end of the IDLE cycle.
- `lat_en` is high for exactly one cycle per write, and at most one bit is ever set.
- At least one cycle with `lat_en` = 0 and stable `lat_d` precedes and follows every enable pulse.

## Configuration
- `LBW_BACK2BACK_EN`
  - Defined: in HOLD, arbitration runs with the same rules as IDLE. If any `req` is high, the block grants, captures and goes straight to SETUP, so consecutive writes take 3 cycles. `busy` stays high. The HOLD guarantees still hold, because `lat_d` changes only on entry to SETUP.
  - Undefined: HOLD always returns to IDLE; 4 cycles per write.

## Test plan
- Reset, then single write: `req`=0001, addr 2, data 0xA5. Expect `gnt`=0001 at t+1, `lat_d`=0xA5 from t+1, `lat_en`=0100 at t+2 only, `busy` high t+1..t+3, `lat_d`=0xA5 persisting in IDLE.
- Fairness: `req`=1111 held, each requester dropping `req` after its grant. Expect grant order 0,1,2,3. Then re-raise all; expect 0 again, because `rr_ptr` wrapped to 0.
- Pointer skip: after granting requester 1, set `req`=0001. Expect requester 0 granted (search from 2 wraps to 0), then `rr_ptr`=1.
- Invalid address with DEPTH=3: write to addr 3. Expect `err` pulse at t+1, `lat_en` 0 throughout, `gnt` still issued.
- Reset in OPEN: assert `rst` in the OPEN cycle. Expect `lat_en`=0, `lat_d`=0 and `busy`=0 the next cycle, and no `gnt`/`err` after reset.
- Back-to-back: with `LBW_BACK2BACK_EN` defined and `req`=0011 held, expect grants 3 cycles apart. Without it, 4 cycles apart, with one IDLE cycle where `busy`=0.
